// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 size codes, FSM states and
// the fault classification helper used by the top level.
package lsu_pkg;

  // RV32 load/store size and sign codes
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  // Fixed three-phase access sequence
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // True when the access is misaligned or the size code is illegal.
  // Unsigned codes only make sense for loads, so a store with BU/HU faults.
  function automatic logic access_fault(input logic       we,
                                        input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic f;
    f = 1'b0;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_BU:   f = we;
      F3_H:    f = addr_lo[0];
      F3_HU:   f = addr_lo[0] | we;
      F3_W:    f = (addr_lo != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Pure combinational lane logic: store byte replication and write mask,
// load byte/halfword extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_word,
  output logic [31:0] store_data,
  output logic [3:0]  store_mask,
  output logic [31:0] load_data
);

  logic [7:0]  rbytes [4];
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // Split the read word into byte lanes
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbytes[gi] = rdata_word[8*gi +: 8];
  end

  assign rbyte = rbytes[addr_lo];
  assign rhalf = addr_lo[1] ? rdata_word[31:16] : rdata_word[15:0];

  // Store: replicate the right-aligned data across lanes and pick the mask
  always_comb begin
    store_data = 32'b0;
    store_mask = 4'b0000;
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{wdata[7:0]}};
        store_mask = 4'b0001 << addr_lo;
      end
      2'b01: begin
        store_data = {2{wdata[15:0]}};
        store_mask = 4'b0011 << addr_lo;
      end
      2'b10: begin
        store_data = wdata;
        store_mask = 4'b1111;
      end
      default: begin
        store_data = 32'b0;
        store_mask = 4'b0000;
      end
    endcase
  end

  // Load: extract the addressed lane and extend to 32 bits
  always_comb begin
    load_data = 32'b0;
    case (funct3)
      F3_B:    load_data = {{24{rbyte[7]}}, rbyte};
      F3_BU:   load_data = {24'b0, rbyte};
      F3_H:    load_data = {{16{rhalf[15]}}, rhalf};
      F3_HU:   load_data = {16'b0, rhalf};
      F3_W:    load_data = rdata_word;
      default: load_data = 32'b0;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one request per three cycles, drives a single
// access cycle to data memory and returns a registered one-cycle response.
module lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  state_e      state_reg, state_next;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic        fault_reg;

  logic        fault;
  logic        store_ok;
  logic [31:0] store_data;
  logic [3:0]  store_mask;
  logic [31:0] load_data;

  lsu_align u_align (
    .funct3     (funct3_reg),
    .addr_lo    (addr_reg[1:0]),
    .wdata      (wdata_reg),
    .rdata_word (mem_rdata),
    .store_data (store_data),
    .store_mask (store_mask),
    .load_data  (load_data)
  );

  assign fault = access_fault(we_reg, funct3_reg, addr_reg[1:0]);

  // Reset is gated in combinationally so a reset landing mid-access never
  // reaches memory and a reset landing in RESP drops the pulse immediately.
  assign store_ok   = (state_reg == ST_ACCESS) && we_reg && !fault && !rst;
  assign mem_we     = store_ok;
  assign mem_wmask  = store_ok ? store_mask : 4'b0000;
  assign mem_wdata  = store_ok ? store_data : 32'b0;
  assign mem_addr   = addr_reg;
  assign req_ready  = (state_reg == ST_IDLE) && !rst;
  assign resp_valid = (state_reg == ST_RESP) && !rst;
  assign resp_rdata = rdata_reg;
  assign resp_fault = fault_reg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: fixed IDLE -> ACCESS -> RESP -> IDLE walk
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (req_valid) state_next = ST_ACCESS;
      ST_ACCESS: state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Capture the request on handshake; inputs are ignored afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      addr_reg   <= 32'b0;
      wdata_reg  <= 32'b0;
    end else if (state_reg == ST_IDLE && req_valid) begin
      we_reg     <= req_we;
      funct3_reg <= req_funct3;
      addr_reg   <= req_addr;
      wdata_reg  <= req_wdata;
    end
  end

  // Register the response at the end of ACCESS and hold it until the next one
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= 32'b0;
      fault_reg <= 1'b0;
    end else if (state_reg == ST_ACCESS) begin
      rdata_reg <= (fault || we_reg) ? 32'b0 : load_data;
      fault_reg <= fault;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with a small masked-write word memory.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_clr = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [16];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_fault (resp_fault),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'b0;
    end else if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_wmask[i]) mem[mem_addr[5:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // One full transaction, entered and left at #1 after a posedge in IDLE.
  task automatic xfer(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_fault,
                      input logic exp_we, input logic [3:0] exp_mask,
                      input logic [31:0] exp_wdata);
    check_eq({tag, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    // junk request while busy must be ignored
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'hFFFF_FFFC; req_wdata = 32'hFFFF_FFFF;
    #1;
    check_eq({tag, ".mem_we"}, {31'b0, mem_we}, {31'b0, exp_we});
    check_eq({tag, ".mask"}, {28'b0, mem_wmask}, {28'b0, exp_mask});
    check_eq({tag, ".wdata"}, mem_wdata, exp_wdata);
    check_eq({tag, ".addr"}, mem_addr, a);
    check_eq({tag, ".acc_rv"}, {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check_eq({tag, ".rv"}, {31'b0, resp_valid}, 32'd1);
    check_eq({tag, ".rdata"}, resp_rdata, exp_rd);
    check_eq({tag, ".fault"}, {31'b0, resp_fault}, {31'b0, exp_fault});
    check_eq({tag, ".ready_busy"}, {31'b0, req_ready}, 32'd0);
    $display("xfer %s we=%0b f3=%03b addr=%08h rdata=%08h fault=%0b", tag, we, f3, a,
             resp_rdata, resp_fault);
    @(posedge clk); #1;
    check_eq({tag, ".rv_end"}, {31'b0, resp_valid}, 32'd0);
    check_eq({tag, ".hold"}, resp_rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc_cycle [$];
    int resp_cnt;
    int rv_cnt;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    mem_clr = 1'b0;
    check_eq("rst.ready", {31'b0, req_ready}, 32'd0);
    check_eq("rst.rv", {31'b0, resp_valid}, 32'd0);
    check_eq("rst.rdata", resp_rdata, 32'd0);
    check_eq("rst.fault", {31'b0, resp_fault}, 32'd0);
    check_eq("rst.mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rst.addr", mem_addr, 32'd0);
    rst = 1'b0;
    #1;
    check_eq("rst.ready_after", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Stores and loads
    xfer("sw10", 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1, 4'b1111, 32'hDEADBEEF);
    check_eq("sw10.mem", mem[4], 32'hDEADBEEF);
    xfer("sb13", 1'b1, 3'b000, 32'h13, 32'h000000A5, 32'h0, 1'b0, 1'b1, 4'b1000, 32'hA5A5A5A5);
    xfer("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA5ADBEEF, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("sw00", 1'b1, 3'b010, 32'h00, 32'h80F07F01, 32'h0, 1'b0, 1'b1, 4'b1111, 32'h80F07F01);
    xfer("lb03", 1'b0, 3'b000, 32'h03, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("lbu03", 1'b0, 3'b100, 32'h03, 32'h0, 32'h00000080, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("lh00", 1'b0, 3'b001, 32'h00, 32'h0, 32'h00007F01, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("lhu02", 1'b0, 3'b101, 32'h02, 32'h0, 32'h000080F0, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("lh02", 1'b0, 3'b001, 32'h02, 32'h0, 32'hFFFF80F0, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("lb01", 1'b0, 3'b000, 32'h01, 32'h0, 32'h0000007F, 1'b0, 1'b0, 4'b0000, 32'h0);
    xfer("sh16", 1'b1, 3'b001, 32'h16, 32'h00001234, 32'h0, 1'b0, 1'b1, 4'b1100, 32'h12341234);
    xfer("lw14", 1'b0, 3'b010, 32'h14, 32'h0, 32'h12340000, 1'b0, 1'b0, 4'b0000, 32'h0);

    // Faults: misaligned and illegal codes
    xfer("lw06", 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
    xfer("sh01", 1'b1, 3'b001, 32'h01, 32'h0000FFFF, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
    xfer("sbu00", 1'b1, 3'b100, 32'h00, 32'h000000FF, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
    xfer("ld011", 1'b0, 3'b011, 32'h00, 32'h0, 32'h0, 1'b1, 1'b0, 4'b0000, 32'h0);
    check_eq("fault.mem0", mem[0], 32'h80F07F01);
    xfer("lw00", 1'b0, 3'b010, 32'h00, 32'h0, 32'h80F07F01, 1'b0, 1'b0, 4'b0000, 32'h0);

    // Reset during the ACCESS cycle of a store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'h11223344;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rstacc.mem_we", {31'b0, mem_we}, 32'd0);
    check_eq("rstacc.rv", {31'b0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("rstacc.ready", {31'b0, req_ready}, 32'd1);
    check_eq("rstacc.rdata", resp_rdata, 32'd0);
    rv_cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) rv_cnt++;
    end
    check_eq("rstacc.no_resp", rv_cnt, 32'd0);
    check_eq("rstacc.mem", mem[8], 32'd0);
    $display("xfer rst_in_access addr=00000020 mem=%08h", mem[8]);

    // Back-to-back requests with req_valid held high
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    resp_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req_valid && req_ready) acc_cycle.push_back(i);
      if (resp_valid) resp_cnt++;
    end
    req_valid = 1'b0;
    check_eq("b2b.accepts", acc_cycle.size(), 32'd4);
    check_eq("b2b.resps", resp_cnt, 32'd4);
    for (int i = 1; i < acc_cycle.size(); i++)
      check_eq("b2b.gap", acc_cycle[i] - acc_cycle[i-1], 32'd3);
    check_eq("b2b.rdata", resp_rdata, 32'hA5ADBEEF);
    $display("xfer b2b accepts=%0d resps=%0d", acc_cycle.size(), resp_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter: none; address and data widths are fixed at 32 bits.
REQ-002 clk  in  1  single clock, all state updates on posedge.
REQ-003 rst  in  1  reset; synchronous, active-high.
REQ-004 req_valid  in  1  pipeline presents a load/store request.
REQ-005 req_ready  out  1  LSU can accept a request this cycle.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RV32 size/sign code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 req_addr  in  32  byte address.
REQ-009 req_wdata  in  32  store data, right-aligned.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-012 resp_fault  out  1  misaligned or illegal access; valid with resp_valid.
REQ-013 mem_addr  out  32  address to data memory.
REQ-014 mem_wdata  out  32  lane-replicated store data.
REQ-015 mem_wmask  out  4  byte-lane write mask.
REQ-016 mem_we  out  1  write enable; memory writes on posedge when high.
REQ-017 mem_rdata  in  32  memory read word, combinational from mem_addr while mem_we=0.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, RESP; IDLE->ACCESS on req_valid&&req_ready, ACCESS->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 req_ready SHALL be 1 only in IDLE; the handshake captures req_we, req_funct3, req_addr and req_wdata into registers.
REQ-020 Latency SHALL be fixed: handshake at edge N, ACCESS during cycle N+1, resp_valid high for exactly the cycle N+2; throughput is one access per 3 cycles.
REQ-021 Misaligned SHALL mean H/HU with addr[0]=1 or W with addr[1:0]!=0; illegal SHALL mean funct3 in {011,110,111}, or a store with funct3 in {100,101}.
REQ-022 In ACCESS, mem_addr SHALL be the captured address; mem_we SHALL be 1 only for a legal, aligned store and only while rst=0.
REQ-023 Store lanes: B -> mem_wdata={4{wdata[7:0]}}, mask=4'b0001<<addr[1:0]; H -> {2{wdata[15:0]}}, mask=4'b0011<<addr[1:0]; W -> wdata, mask=4'b1111.
REQ-024 Outside ACCESS, or on a fault, mem_we and mem_wmask SHALL be 0 and mem_wdata SHALL be 0; mem_addr SHALL hold the captured address.
REQ-025 Loads SHALL sample mem_rdata at the end of ACCESS: select byte addr[1:0] or halfword addr[1], then sign-extend (B/H) or zero-extend (BU/HU); W passes the word through.
REQ-026 On a fault, memory SHALL NOT be written, resp_fault=1 and resp_rdata=0; otherwise resp_fault=0.
REQ-027 resp_rdata and resp_fault SHALL be registered, and SHALL be held until the next response.
REQ-028 The LSU SHALL NOT apply back-pressure on responses; the consumer must accept resp_valid in the cycle it is asserted.
REQ-029 req_valid in non-IDLE states SHALL be ignored, and request inputs may change without effect.

Reset
REQ-030 While rst=1, the LSU SHALL hold state=IDLE, resp_valid=0, resp_rdata=0, resp_fault=0, all captured request registers=0, and mem_we=0.
REQ-031 Reset asserted in ACCESS SHALL suppress the pending write in that same cycle; reset asserted in RESP SHALL drop the response.
REQ-032 req_ready SHALL be 0 while rst=1, and 1 in the first cycle after reset deassertion.

Structure
REQ-033 A shared package lsu_pkg SHALL hold the funct3 encoding enum and the FSM state enum.
REQ-034 A single combinational sub-module, lsu_align, SHALL compute the store mask/replication and the load extract/extend; the FSM and registers stay in lsu.

Verification
REQ-035 SW addr=0x10, wdata=0xDEADBEEF -> ACCESS: mem_we=1, mask=1111, mem_wdata=0xDEADBEEF; resp_valid 2 cycles after handshake, fault=0.
REQ-036 SB addr=0x13, wdata=0x000000A5 -> mask=1000, mem_wdata=0xA5A5A5A5; a following LW from 0x10 returns 0xA5ADBEEF.
REQ-037 With mem word 0x80F07F01: LB at addr 0x03 -> 0xFFFFFF80; LBU at 0x03 -> 0x00000080; LH at 0x00 -> 0x00007F01; LHU at 0x02 -> 0x000080F0.
REQ-038 LW at 0x06 and SH at 0x01 -> no mem_we pulse, resp_fault=1, resp_rdata=0; a store with funct3=100 -> fault.
REQ-039 rst asserted during the ACCESS cycle of SW -> mem_we stays 0, memory is unchanged, no resp_valid, req_ready=1 the cycle after rst deasserts.
REQ-040 Back-to-back req_valid held high -> accepts occur exactly every 3 cycles, with a single resp_valid pulse per accept.
